// File: rtl/sys_bridge_intc_pkg.sv
// Shared constants for the CPU-to-peripheral bridge and interrupt controller:
// window map, controller register offsets, source order and HWInt layout.
package sys_bridge_intc_pkg;

    localparam logic [31:0] TC0_BASE  = 32'h0000_7F00;
    localparam logic [31:0] TC1_BASE  = 32'h0000_7F10;
    localparam logic [31:0] IC_BASE   = 32'h0000_7F20;
    localparam int          WIN_BYTES = 12;

    // Windows are 16-byte aligned, so matching on addr[31:4] picks the window.
    localparam logic [27:0] TC0_TAG = TC0_BASE[31:4];
    localparam logic [27:0] TC1_TAG = TC1_BASE[31:4];
    localparam logic [27:0] IC_TAG  = IC_BASE[31:4];

    localparam logic [1:0] REG_PEND = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd1;
    localparam logic [1:0] REG_VEC  = 2'd2;

    localparam int NSRC    = 3;
    localparam int SRC_TC0 = 0;
    localparam int SRC_TC1 = 1;
    localparam int SRC_EXT = 2;

    // HWInt[7:2] as seen by CP0; sources occupy the low NSRC bits.
    localparam int HWINT_W = 6;

    typedef struct packed {
        logic ic;
        logic tc1;
        logic tc0;
    } win_hit_t;

    // Word address in, so the last word of each 16-byte window is rejected.
    function automatic logic win_match(input logic [27:0] tag, input logic [29:0] waddr);
        return (waddr[29:2] == tag) && (waddr[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/sys_bridge_intc_if.sv
// CPU data-port bundle: the CPU drives address/strobe/data, the bridge
// returns load data and the out-of-window flag in the same cycle.
interface sys_bridge_intc_if;
    logic [31:0] cpu_addr;
    logic        cpu_we;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        addr_err;

    modport master (output cpu_addr, cpu_we, cpu_wdata, input cpu_rdata, addr_err);
    modport slave  (input cpu_addr, cpu_we, cpu_wdata, output cpu_rdata, addr_err);
endinterface

// File: rtl/sys_bridge_intc_irq_edge_pend.sv
// One interrupt source: rising-edge detector feeding a pending flop whose
// software clear loses to a simultaneous new edge.
module irq_edge_pend (
    input  logic clk,
    input  logic reset,
    input  logic i_src,
    input  logic i_clr,
    output logic o_pend,
    output logic o_pend_next
);

    logic r_prev;
    logic r_pend;
    logic w_rise;

    // prev clears on reset, so a source already high at release counts as an edge.
    assign w_rise      = i_src & ~r_prev;
    assign o_pend_next = (r_pend & ~i_clr) | w_rise;
    assign o_pend      = r_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_prev <= i_src;
            r_pend <= o_pend_next;
        end
    end

endmodule

// File: rtl/sys_bridge_intc.sv
// Address decode, per-device write enables and load mux for TC0/TC1, plus the
// PEND/MASK/VEC interrupt controller driving a registered HWInt vector.
module sys_bridge_intc
    import sys_bridge_intc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    sys_bridge_intc_if.slave    bus,
    output logic [29:0]         o_dev_addr,
    output logic [31:0]         o_dev_wdata,
    output logic                o_tc0_we,
    output logic                o_tc1_we,
    input  logic [31:0]         i_tc0_rdata,
    input  logic [31:0]         i_tc1_rdata,
    input  logic                i_tc0_irq,
    input  logic                i_tc1_irq,
    input  logic                i_ext_irq,
    output logic [HWINT_W-1:0]  o_hw_int,
    output logic                o_irq_any
);

    win_hit_t          w_hit;
    logic [1:0]        w_reg_sel;
    logic              w_ic_we;
    logic [NSRC-1:0]   w_src;
    logic [NSRC-1:0]   w_pend_clr;
    logic [NSRC-1:0]   w_pend;
    logic [NSRC-1:0]   w_pend_next;
    logic [NSRC-1:0]   w_mask_next;
    logic [NSRC-1:0]   w_act;
    logic              w_vec_valid;
    logic [2:0]        w_vec_idx;
    logic [31:0]       w_ic_rdata;
    logic              w_unused;
    logic [NSRC-1:0]   r_mask;
    logic [NSRC-1:0]   r_hw_int;

    assign w_unused = &{1'b0, bus.cpu_addr[1:0]};

    assign w_hit.tc0 = win_match(TC0_TAG, bus.cpu_addr[31:2]);
    assign w_hit.tc1 = win_match(TC1_TAG, bus.cpu_addr[31:2]);
    assign w_hit.ic  = win_match(IC_TAG,  bus.cpu_addr[31:2]);
    assign w_reg_sel = bus.cpu_addr[3:2];

    assign bus.addr_err = ~|w_hit;
    assign o_dev_addr   = bus.cpu_addr[31:2];
    assign o_dev_wdata  = bus.cpu_wdata;
    assign o_tc0_we     = bus.cpu_we & w_hit.tc0;
    assign o_tc1_we     = bus.cpu_we & w_hit.tc1;
    assign w_ic_we      = bus.cpu_we & w_hit.ic;

    assign w_src[SRC_TC0] = i_tc0_irq;
    assign w_src[SRC_TC1] = i_tc1_irq;
    assign w_src[SRC_EXT] = i_ext_irq;

    assign w_pend_clr  = (w_ic_we && w_reg_sel == REG_PEND) ? bus.cpu_wdata[NSRC-1:0] : '0;
    assign w_mask_next = (w_ic_we && w_reg_sel == REG_MASK) ? bus.cpu_wdata[NSRC-1:0] : r_mask;

    genvar g;
    generate
        for (g = 0; g < NSRC; g++) begin : g_src
            irq_edge_pend u_pend (
                .clk         (clk),
                .reset       (reset),
                .i_src       (w_src[g]),
                .i_clr       (w_pend_clr[g]),
                .o_pend      (w_pend[g]),
                .o_pend_next (w_pend_next[g])
            );
        end
    endgenerate

    // hw_int tracks next-state PEND/MASK so an edge or mask write shows one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask   <= '0;
            r_hw_int <= '0;
        end else begin
            r_mask   <= w_mask_next;
            r_hw_int <= w_pend_next & w_mask_next;
        end
    end

    assign o_hw_int  = HWINT_W'(r_hw_int);
    assign o_irq_any = |r_hw_int;

    // Lowest-numbered active source wins: scan downward so the last hit is the lowest.
    assign w_act = w_pend & r_mask;
    always_comb begin
        w_vec_valid = 1'b0;
        w_vec_idx   = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_act[i]) begin
                w_vec_valid = 1'b1;
                w_vec_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        w_ic_rdata = 32'h0;
        case (w_reg_sel)
            REG_PEND: w_ic_rdata = 32'(w_pend);
            REG_MASK: w_ic_rdata = 32'(r_mask);
            REG_VEC:  w_ic_rdata = {28'h0, w_vec_valid, w_vec_idx};
            default:  w_ic_rdata = 32'h0;
        endcase
    end

    always_comb begin
        bus.cpu_rdata = 32'h0;
        if (w_hit.tc0)      bus.cpu_rdata = i_tc0_rdata;
        else if (w_hit.tc1) bus.cpu_rdata = i_tc1_rdata;
        else if (w_hit.ic)  bus.cpu_rdata = w_ic_rdata;
    end

endmodule

// File: tb/tb_sys_bridge_intc.sv
// Directed checks of decode, load mux, edge capture, mask/clear and reset
// for sys_bridge_intc, with hand-computed expected values.
module tb_sys_bridge_intc;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] dev_addr;
    logic [31:0] dev_wdata;
    logic        tc0_we, tc1_we;
    logic [31:0] tc0_rdata, tc1_rdata;
    logic        tc0_irq, tc1_irq, ext_irq;
    logic [5:0]  hw_int;
    logic        irq_any;
    int          n_vec = 0;
    int          n_err = 0;

    sys_bridge_intc_if bus ();

    sys_bridge_intc dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dev_addr  (dev_addr),
        .o_dev_wdata (dev_wdata),
        .o_tc0_we    (tc0_we),
        .o_tc1_we    (tc1_we),
        .i_tc0_rdata (tc0_rdata),
        .i_tc1_rdata (tc1_rdata),
        .i_tc0_irq   (tc0_irq),
        .i_tc1_irq   (tc1_irq),
        .i_ext_irq   (ext_irq),
        .o_hw_int    (hw_int),
        .o_irq_any   (irq_any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
        bus.cpu_addr  = addr;
        bus.cpu_we    = we;
        bus.cpu_wdata = wdata;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        tc0_irq = 1'b0; tc1_irq = 1'b0; ext_irq = 1'b0;
        tc0_rdata = 32'h0; tc1_rdata = 32'h0;
        drive(32'h0, 1'b0, 32'h0);
        tick(); tick();
        chk("rst_hw_int", 32'(hw_int), 32'h0);
        chk("rst_irq_any", 32'(irq_any), 32'h0);
        reset = 1'b0;
        drive(32'h7F20, 1'b0, 32'h0);
        chk("rst_pend", bus.cpu_rdata, 32'h0);
        drive(32'h7F24, 1'b0, 32'h0);
        chk("rst_mask", bus.cpu_rdata, 32'h0);
        tick();

        // Stores into TC0
        drive(32'h7F00, 1'b1, 32'h9);
        chk("st0_tc0_we", 32'(tc0_we), 32'h1);
        chk("st0_tc1_we", 32'(tc1_we), 32'h0);
        chk("st0_err", 32'(bus.addr_err), 32'h0);
        chk("st0_dev_addr", 32'(dev_addr), 32'h1FC0);
        chk("st0_dev_wdata", dev_wdata, 32'h9);
        tick();
        drive(32'h7F04, 1'b1, 32'd5);
        chk("st1_tc0_we", 32'(tc0_we), 32'h1);
        chk("st1_tc1_we", 32'(tc1_we), 32'h0);
        chk("st1_dev_addr", 32'(dev_addr), 32'h1FC1);
        chk("st1_dev_wdata", dev_wdata, 32'd5);
        tick();

        // Loads through the mux
        tc0_rdata = 32'hCAFE_0001; tc1_rdata = 32'h1234_5678;
        drive(32'h7F04, 1'b0, 32'h0);
        chk("ld_tc0_we", 32'(tc0_we), 32'h0);
        chk("ld_tc0", bus.cpu_rdata, 32'hCAFE_0001);
        drive(32'h7F18, 1'b0, 32'h0);
        chk("ld_tc1", bus.cpu_rdata, 32'h1234_5678);
        chk("ld_tc1_err", 32'(bus.addr_err), 32'h0);
        drive(32'h7F10, 1'b1, 32'h7);
        chk("st_tc1_we", 32'(tc1_we), 32'h1);
        chk("st_tc1_tc0we", 32'(tc0_we), 32'h0);

        // Out-of-window accesses
        drive(32'h7F0C, 1'b0, 32'h0);
        chk("ld7F0C_err", 32'(bus.addr_err), 32'h1);
        chk("ld7F0C_data", bus.cpu_rdata, 32'h0);
        drive(32'h7F40, 1'b0, 32'h0);
        chk("ld7F40_err", 32'(bus.addr_err), 32'h1);
        chk("ld7F40_data", bus.cpu_rdata, 32'h0);
        drive(32'h7F0C, 1'b1, 32'hFFFF_FFFF);
        chk("st7F0C_we", 32'(tc0_we), 32'h0);
        chk("st7F0C_err", 32'(bus.addr_err), 32'h1);
        tick();
        drive(32'h7F2C, 1'b1, 32'h7);
        chk("st7F2C_err", 32'(bus.addr_err), 32'h1);
        tick();
        drive(32'h7F24, 1'b0, 32'h0);
        chk("miss_mask", bus.cpu_rdata, 32'h0);
        drive(32'h7F20, 1'b0, 32'h0);
        chk("miss_pend", bus.cpu_rdata, 32'h0);

        // TC0 edge with MASK=001
        drive(32'h7F24, 1'b1, 32'h1);
        tick();
        drive(32'h7F24, 1'b0, 32'h0);
        chk("mask_rd", bus.cpu_rdata, 32'h1);
        tc0_irq = 1'b1;
        #1;
        chk("edge_hw_n", 32'(hw_int), 32'h0);
        tick();
        chk("edge_hw_n1", 32'(hw_int), 32'h1);
        chk("edge_any", 32'(irq_any), 32'h1);
        drive(32'h7F20, 1'b0, 32'h0);
        chk("edge_pend", bus.cpu_rdata, 32'h1);
        drive(32'h7F28, 1'b0, 32'h0);
        chk("edge_vec", bus.cpu_rdata, 32'h8);
        tick(); tick(); tick();
        chk("held_hw", 32'(hw_int), 32'h1);
        drive(32'h7F28, 1'b1, 32'h0);
        tick();
        chk("vec_ro_hw", 32'(hw_int), 32'h1);
        drive(32'h7F20, 1'b1, 32'h1);
        tick();
        drive(32'h7F20, 1'b0, 32'h0);
        chk("held_noreedge_pend", bus.cpu_rdata, 32'h0);
        chk("held_noreedge_hw", 32'(hw_int), 32'h0);

        // New edge wins over a same-cycle clear
        tc0_irq = 1'b0; tick();
        tc0_irq = 1'b1; tick();
        chk("re_pend_hw", 32'(hw_int), 32'h1);
        tc0_irq = 1'b0; tick();
        tc0_irq = 1'b1;
        drive(32'h7F20, 1'b1, 32'h1);
        tick();
        drive(32'h7F20, 1'b0, 32'h0);
        chk("setwin_pend", bus.cpu_rdata, 32'h1);
        chk("setwin_hw", 32'(hw_int), 32'h1);

        // Masked TC1, then unmask
        tc0_irq = 1'b0;
        drive(32'h7F20, 1'b1, 32'h7);
        tick();
        drive(32'h7F24, 1'b1, 32'h0);
        tick();
        tc1_irq = 1'b1;
        drive(32'h7F20, 1'b0, 32'h0);
        tick();
        chk("m0_hw", 32'(hw_int), 32'h0);
        chk("m0_pend", bus.cpu_rdata, 32'h2);
        drive(32'h7F28, 1'b0, 32'h0);
        chk("m0_vec", bus.cpu_rdata, 32'h0);
        drive(32'h7F24, 1'b1, 32'h2);
        chk("m2_same_cycle_hw", 32'(hw_int), 32'h0);
        tick();
        chk("m2_hw", 32'(hw_int), 32'h2);
        drive(32'h7F28, 1'b0, 32'h0);
        chk("m2_vec", bus.cpu_rdata, 32'h9);

        // TC0 + EXT with MASK=7, priority and clear
        tc1_irq = 1'b0;
        drive(32'h7F20, 1'b1, 32'h7);
        tick();
        tc0_irq = 1'b1; ext_irq = 1'b1;
        drive(32'h7F24, 1'b1, 32'h7);
        tick();
        chk("both_hw", 32'(hw_int), 32'h5);
        drive(32'h7F28, 1'b0, 32'h0);
        chk("both_vec", bus.cpu_rdata, 32'h8);
        drive(32'h7F20, 1'b1, 32'h1);
        tick();
        drive(32'h7F28, 1'b0, 32'h0);
        chk("ext_vec", bus.cpu_rdata, 32'hA);
        chk("ext_hw", 32'(hw_int), 32'h4);

        // Reset mid-operation, then power-on edge from held sources
        drive(32'h7F20, 1'b0, 32'h0);
        reset = 1'b1;
        tick();
        chk("mrst_hw", 32'(hw_int), 32'h0);
        chk("mrst_pend", bus.cpu_rdata, 32'h0);
        drive(32'h7F24, 1'b0, 32'h0);
        chk("mrst_mask", bus.cpu_rdata, 32'h0);
        reset = 1'b0;
        drive(32'h7F20, 1'b0, 32'h0);
        tick();
        chk("poweron_pend", bus.cpu_rdata, 32'h5);
        chk("poweron_hw", 32'(hw_int), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sys_bridge_intc.md
Name: sys_bridge_intc

Overview:
- Memory-mapped bridge plus interrupt controller between the CPU data port and the peripheral bus: two timer instances (TC0, TC1) and one external interrupt line.
- Decodes CPU addresses into per-device write enables and a read-data mux.
- Captures timer/external interrupt edges into a pending register with software mask and clear.
- Drives a registered hardware-interrupt vector to CP0.

Parameters:
- TC0_BASE, 32'h0000_7F00, TC0 window base; window is 12 bytes (3 words).
- TC1_BASE, 32'h0000_7F10, TC1 window base; window is 12 bytes.
- IC_BASE, 32'h0000_7F20, controller register window base; window is 12 bytes.
- NSRC, 3, number of interrupt sources (fixed order: TC0, TC1, EXT).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_addr  in  32  CPU byte address (word aligned)
- cpu_we  in  1  CPU store strobe
- cpu_wdata  in  32  CPU store data
- cpu_rdata  out  32  load data (combinational)
- addr_err  out  1  access outside all windows
- dev_addr  out  30  forwarded cpu_addr[31:2]
- dev_wdata  out  32  forwarded cpu_wdata
- tc0_we  out  1  TC0 write enable
- tc1_we  out  1  TC1 write enable
- tc0_rdata  in  32  TC0 read data
- tc1_rdata  in  32  TC1 read data
- tc0_irq  in  1  TC0 interrupt, level
- tc1_irq  in  1  TC1 interrupt, level
- ext_irq  in  1  external interrupt, level, synchronous to clk
- hw_int  out  6  CP0 HWInt[7:2]; bits [2:0] = TC0, TC1, EXT; bits [5:3] = 0
- irq_any  out  1  OR of hw_int

Behaviour:
- Decode: hit when cpu_addr[31:4] matches window base [31:4] and cpu_addr[3:2] != 2'b11.
  - tc0_we = cpu_we & hit_tc0; tc1_we = cpu_we & hit_tc1.
  - addr_err = no hit (loads or stores).
  - Stores with addr_err are dropped. Loads with addr_err return 0.
- Read mux: cpu_rdata selects tc0_rdata, tc1_rdata, or IC register by window; 0 on miss.
- IC registers, selected by cpu_addr[3:2]:
  - 0 PEND (NSRC bits, zero-extended): read; write-1-to-clear.
  - 1 MASK (NSRC bits): read/write; reset 3'b000.
  - 2 VEC: read-only; {28'b0, valid, idx[2:0]}; idx = lowest-numbered pending & mask bit; valid=0 gives idx=0. Writes to VEC are ignored.
- Edge capture:
  - prev[NSRC-1:0] registers the raw sources every cycle.
  - rise = src & ~prev.
  - PEND_next = (PEND & ~clr) | rise, where clr = wdata bits when writing PEND. Set wins over clear in the same cycle.
  - A source held high sets PEND once only. Re-pending needs a low-then-high transition.
- Output timing:
  - hw_int[2:0] is registered: hw_int <= PEND_next & MASK_next. It reflects a new edge one cycle after the source rises (edge cycle N, hw_int high at N+1).
  - A MASK write takes effect on hw_int the next cycle.
  - irq_any = |hw_int (combinational from the register).
- Reset:
  - PEND, MASK, prev, and hw_int all clear.
  - A source already high at reset release sets PEND on the first cycle after reset, since prev=0 (intended power-on edge).
  - Reset mid-operation discards pending state; timers are reset independently.
- No back-pressure: every access completes in the cycle presented. There is no state machine beyond the edge/pending registers.

Decomposition:
- Shared package holds:
  - window bases and size;
  - IC register offsets (PEND=0, MASK=1, VEC=2);
  - source index constants (SRC_TC0=0, SRC_TC1=1, SRC_EXT=2);
  - HWInt bit map.
- One sub-module, irq_edge_pend: per-source prev/pend flop with set-priority clear. Instantiated NSRC times (or vectorised).
- Decode and read mux stay in the top level.

Test Plan:
- Store 32'h9 to 0x7F00, then 32'd5 to 0x7F04 -> tc0_we high exactly in those two cycles; dev_addr = 30'h1FC0 / 30'h1FC1; tc1_we stays 0; addr_err 0.
- Load 0x7F0C and 0x7F40 -> addr_err=1, cpu_rdata=0; store to 0x7F0C -> tc0_we=0, no IC state change.
- MASK=3'b001; pulse tc0_irq high from cycle 10 and hold -> PEND=001, hw_int=6'b000001 at cycle 11; VEC=32'h8; hw_int stays 1 while held (no re-edge).
- PEND set; write 32'h1 to PEND in the same cycle tc0_irq rises again after a low period -> PEND bit0 remains 1.
- tc1_irq pending with MASK=0 -> hw_int=0, PEND=010, VEC=0; then write MASK=3'b010 -> hw_int=6'b000010 next cycle, VEC=32'h9.
- TC0 and EXT pending with MASK=7 -> VEC=32'h8; clear PEND bit0 -> VEC=32'hA. Assert reset -> PEND=0, MASK=0, hw_int=0 next cycle.
